// File: rtl/ram_burst_master_pkg.sv
// Shared definitions for the RAM burst master: FSM state encoding and default widths.
package ram_burst_master_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_e;

endpackage

// File: rtl/ram_burst_master.sv
// Burst master for a single-port RAM with combinational read: streams write words into
// consecutive addresses, or fetches consecutive words through a one-word output register.
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_LEN = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [ADDR_W:0]     len_sat;

    always_comb begin
        len_sat     = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        done        = 1'b0;
        mem_load    = 1'b0;
        mem_in      = '0;
        mem_address = addr_q;

        case (state_q)
            IDLE: begin
                cmd_ready   = 1'b1;
                mem_address = cmd_addr;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    count_d = len_sat;
                    if (len_sat == '0) begin
                        state_d = DONE;
                    end else if (cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        // First word is fetched on the accept edge so rd_valid rises one cycle later
                        rd_data_d  = mem_out;
                        rd_valid_d = 1'b1;
                        addr_d     = cmd_addr + 1'b1;
                        count_d    = len_sat - ONE_LEN;
                        state_d    = READ;
                    end
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                mem_in   = wr_data;
                mem_load = wr_valid;
                if (wr_valid) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - ONE_LEN;
                    if (count_q == ONE_LEN) begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if ((!rd_valid_q || rd_ready) && count_q != '0) begin
                    rd_data_d  = mem_out;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    count_d    = count_q - ONE_LEN;
                end else if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset acts on the combinational outputs too, so an abandoned write never loads the RAM
        if (reset) begin
            cmd_ready   = 1'b1;
            wr_ready    = 1'b0;
            done        = 1'b0;
            mem_load    = 1'b0;
            mem_in      = '0;
            mem_address = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the memory word width.
REQ-002 SHALL have parameter ADDR_W, default 9, the memory address width, giving 512 words.
REQ-003 SHALL have these ports; one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  burst start address.
- cmd_len  in  ADDR_W+1  word count, 0..512.
- wr_valid  in  1  write word offered.
- wr_ready  out  1  write word accepted.
- wr_data  in  DATA_W  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts the read word.
- rd_data  out  DATA_W  read word.
- done  out  1  one-cycle pulse when a burst ends.
- mem_in  out  DATA_W  to the RAM in port.
- mem_load  out  1  to the RAM load port.
- mem_address  out  ADDR_W  to the RAM address port.
- mem_out  in  DATA_W  RAM combinational read data for mem_address.

Function
REQ-004 SHALL use states IDLE, WRITE, READ and DONE.
REQ-005 IDLE: cmd_ready=1; on cmd_valid, SHALL latch addr/len/dir and go to WRITE or READ, or to DONE if cmd_len=0.
REQ-006 cmd_ready SHALL be 0 in every state other than IDLE.
REQ-007 WRITE: wr_ready=1 and mem_address=current address; mem_in=wr_data and mem_load=wr_valid, all combinational.
REQ-008 WRITE: on each wr_valid, SHALL advance the address by 1 and decrement the remaining count; on reaching 0, SHALL go to DONE.
REQ-009 The address SHALL wrap from 511 to 0; a 512-word burst SHALL touch every location exactly once.
REQ-010 READ: mem_load SHALL be 0, mem_address = the fetch address, and rd_data/rd_valid SHALL come from a one-word output register.
REQ-011 READ: when the register is empty or being consumed (rd_valid and rd_ready) and fetches remain, SHALL capture mem_out, set rd_valid=1 and advance the fetch address.
REQ-012 READ: the first rd_valid SHALL appear 1 cycle after command acceptance.
REQ-013 READ: with rd_ready held high, SHALL deliver 1 word per cycle.
REQ-014 READ: rd_data SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-015 READ: SHALL go to DONE in the cycle the last word is consumed.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE; no command SHALL be accepted in DONE.
REQ-017 Outside WRITE, mem_load SHALL be 0 and wr_ready SHALL be 0; outside READ, rd_valid SHALL be 0.
REQ-018 wr_valid SHALL be ignored outside WRITE, and rd_ready SHALL be ignored when rd_valid=0.
REQ-019 cmd_len SHALL be treated as modulo-free: values above 512 SHALL saturate to 512.

Reset
REQ-020 reset=1 SHALL force IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0, mem_load=0, mem_address=0, mem_in=0 and counters=0.
REQ-021 Reset mid-burst SHALL abandon the burst without a done pulse; no mem_load SHALL occur in the reset cycle.

Structure
REQ-022 A shared package SHALL hold the state enum and the DATA_W/ADDR_W defaults.
REQ-023 The block SHALL be a single module with no sub-module; it SHALL connect directly to RAM512 ports.

Verification
REQ-024 Write burst addr=5, len=3, data 0x1111/0x2222/0x3333 -> RAM[5..7] hold these values; done pulses 1 cycle after the third beat.
REQ-025 Read burst addr=5, len=3, rd_ready=1 -> rd_data 0x1111, 0x2222, 0x3333 on consecutive cycles; done follows.
REQ-026 Write addr=510, len=4 -> locations 510, 511, 0 and 1 written (wrap).
REQ-027 Read with rd_ready toggling 1/0 -> rd_data held while stalled; no word lost or duplicated; mem_load stays 0.
REQ-028 cmd_len=0 -> done pulses 1 cycle after accept; no memory activity.
REQ-029 Reset after 2 of 4 write beats -> state IDLE, no done pulse, remaining locations unchanged, next command accepted.
